uart_echo_led: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/byte_fifo.sv | 52 +++++
 rtl/uart_echo_led.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo/LED block.
//   rx_state_t / tx_state_t : receiver and transmitter FSM encodings
//   UART_DATA_BITS          : payload bits per 8N1 frame
//   cnt_width()             : width of a bit-period counter for a given CLKS_PER_BIT
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_t;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_t;

  // Counter only has to reach CLKS_PER_BIT-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO used to re-time received bytes into the transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full unless popping in the same cycle)
//   pop, dout  : read request and head-of-queue data (pop is ignored when empty)
//   full/empty : occupancy flags
// DEPTH must be a power of two; pointers carry one extra MSB to tell full from empty.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_ok = pop && !empty;
  // A simultaneous pop frees the slot being written, so a full FIFO still accepts it.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: empty pointers mask its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_echo_led.sv
// UART receive / re-timed echo / LED display block.
//   clk, rst_n : system clock, asynchronous active-low reset
//   usb_rx     : 8N1 receive line, idle high, asynchronous to clk
//   tx_hold    : when high the transmitter starts no new frame
//   usb_tx     : 8N1 transmit line, idle high (raw copy of usb_rx when ECHO_MODE == 0)
//   led        : low LED_W bits of the last correctly framed byte
//   frame_err  : sticky, a stop bit was sampled low
//   overflow   : sticky, a received byte was dropped because the echo FIFO was full
module uart_echo_led
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LED_W        = 8,
  parameter int unsigned ECHO_MODE    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             usb_rx,
  input  logic             tx_hold,
  output logic             usb_tx,
  output logic [LED_W-1:0] led,
  output logic             frame_err,
  output logic             overflow
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam int unsigned DW = UART_DATA_BITS;
  localparam int unsigned BW = $clog2(DW);

  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DataLast = BW'(DW - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser and start-edge detect
  // ---------------------------------------------------------------------------
  // All three flops reset low, so a falling edge needs a genuinely high
  // synchronised sample first; a line held low across reset release is ignored.
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= usb_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  rx_state_t        rx_state_q, rx_state_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]    rx_bit_q, rx_bit_d;
  logic [DW-1:0]    rx_sh_q, rx_sh_d;
  logic             rx_push;   // good byte in rx_sh_q this cycle
  logic             rx_ferr;   // stop bit sampled low this cycle
  logic [LED_W-1:0] led_q;
  logic             frame_err_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // Line back high at mid-start means a glitch, not a frame.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[DW-1:1]};
          rx_bit_d = rx_bit_q + BW'(1);
          if (rx_bit_q == DataLast) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          if (rx_sync_q) rx_push = 1'b1;
          else           rx_ferr = 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      led_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      if (rx_push) led_q <= rx_sh_q[LED_W-1:0];
      if (rx_ferr) frame_err_q <= 1'b1;
    end
  end

  assign led       = led_q;
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Echo path: FIFO + transmitter, or a raw wire in legacy mode
  // ---------------------------------------------------------------------------
  if (ECHO_MODE != 0) begin : g_echo
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          overflow_q;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [BW-1:0] tx_bit_q, tx_bit_d;
    logic [DW-1:0] tx_sh_q, tx_sh_d;
    logic          tx_line_q, tx_line_d;

    byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .pop   (fifo_pop),
      .din   (rx_sh_q),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
    );

    always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      fifo_pop   = 1'b0;
      unique case (tx_state_q)
        TxIdle: begin
          tx_cnt_d = '0;
          if (!fifo_empty && !tx_hold) begin
            fifo_pop   = 1'b1;
            tx_sh_d    = fifo_dout;
            tx_state_d = TxStart;
          end
        end
        TxStart: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = TxData;
          end
        end
        TxData: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_d = '0;
            tx_sh_d  = {1'b0, tx_sh_q[DW-1:1]};
            tx_bit_d = tx_bit_q + BW'(1);
            if (tx_bit_q == DataLast) tx_state_d = TxStop;
          end
        end
        TxStop: begin
          if (tx_cnt_q == BitLast) begin
            tx_cnt_d   = '0;
            tx_state_d = TxIdle;
          end
        end
        default: tx_state_d = TxIdle;
      endcase
    end

    // Line level follows the current state through one register so usb_tx is glitch-free.
    always_comb begin
      tx_line_d = 1'b1;
      unique case (tx_state_q)
        TxIdle:  tx_line_d = 1'b1;
        TxStart: tx_line_d = 1'b0;
        TxData:  tx_line_d = tx_sh_q[0];
        TxStop:  tx_line_d = 1'b1;
        default: tx_line_d = 1'b1;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tx_state_q <= TxIdle;
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
        tx_sh_q    <= '0;
        tx_line_q  <= 1'b1;
        overflow_q <= 1'b0;
      end else begin
        tx_state_q <= tx_state_d;
        tx_cnt_q   <= tx_cnt_d;
        tx_bit_q   <= tx_bit_d;
        tx_sh_q    <= tx_sh_d;
        tx_line_q  <= tx_line_d;
        if (rx_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      end
    end

    assign usb_tx   = tx_line_q;
    assign overflow = overflow_q;
  end else begin : g_wire
    assign usb_tx   = usb_rx;
    assign overflow = 1'b0;
  end

endmodule
